// File: rtl/obstacle_level_engine_if.sv
// Bundles the game-control inputs and renderer-facing outputs of the obstacle/level engine.
// The engine sits on the slave side; the master side drives tick/start/jump_height.
interface obstacle_level_engine_if #(
  parameter int NUM_OBS = 4,
  parameter int X_W     = 11,
  parameter int JH_W    = 10,
  parameter int TIME_W  = 11,
  parameter int LVL_W   = 3
);
  logic                   tick;
  logic                   start;
  logic [JH_W-1:0]        jump_height;
  logic [NUM_OBS*X_W-1:0] obs_x;
  logic [NUM_OBS-1:0]     obs_valid;
  logic [LVL_W-1:0]       level;
  logic [TIME_W-1:0]      game_time;
  logic                   menu_screen;
  logic                   play_screen;
  logic                   win_screen;
  logic                   lose_screen;
  logic                   hit;

  modport master (
    output tick, start, jump_height,
    input  obs_x, obs_valid, level, game_time,
    input  menu_screen, play_screen, win_screen, lose_screen, hit
  );

  modport slave (
    input  tick, start, jump_height,
    output obs_x, obs_valid, level, game_time,
    output menu_screen, play_screen, win_screen, lose_screen, hit
  );
endinterface

// File: rtl/obstacle_level_engine.sv
// Game-state FSM plus obstacle scroller for the obstacle runner: scrolls obstacles on each game tick,
// detects player collisions, advances levels and keeps game/level timers.
module obstacle_level_engine #(
  parameter int NUM_OBS     = 4,
  parameter int X_W         = 11,
  parameter int SCREEN_W    = 640,
  parameter int OBS_SPACING = 160,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 24,
  parameter int PLAYER_X    = 64,
  parameter int PLAYER_W    = 16,
  parameter int JH_W        = 10,
  parameter int TIME_W      = 11,
  parameter int LEVEL_TICKS = 600,
  parameter int NUM_LEVELS  = 3,
  parameter int SPEED0      = 2,
  parameter int SPEED_STEP  = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  obstacle_level_engine_if.slave bus
);

  localparam int LVL_W = $clog2(NUM_LEVELS) + 1;
  localparam int LT_W  = $clog2(LEVEL_TICKS) + 1;

  localparam logic [X_W:0]       PLAYER_LEFT  = (X_W+1)'(PLAYER_X);
  localparam logic [X_W:0]       PLAYER_RIGHT = (X_W+1)'(PLAYER_X + PLAYER_W);
  localparam logic [X_W:0]       OBS_W_C      = (X_W+1)'(OBS_W);
  localparam logic [X_W-1:0]     WRAP_C       = X_W'(NUM_OBS * OBS_SPACING);
  localparam logic [X_W-1:0]     SCREEN_W_C   = X_W'(SCREEN_W);
  localparam logic [X_W-1:0]     SPEED0_C     = X_W'(SPEED0);
  localparam logic [X_W-1:0]     SPEED_STEP_C = X_W'(SPEED_STEP);
  localparam logic [JH_W-1:0]    OBS_H_C      = JH_W'(OBS_H);
  localparam logic [LT_W-1:0]    LT_LAST      = LT_W'(LEVEL_TICKS - 1);
  localparam logic [LVL_W-1:0]   LVL_LAST     = LVL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {MENU, PLAY, WIN, LOSE} state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      obs_x_q [NUM_OBS];
  logic [X_W-1:0]      obs_x_d [NUM_OBS];
  logic [NUM_OBS-1:0]  obs_valid_q, obs_valid_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [X_W-1:0]      speed_q, speed_d;
  logic [TIME_W-1:0]   game_time_q, game_time_d;
  logic [LT_W-1:0]     level_time_q, level_time_d;
  logic                hit_q, hit_d;
  logic                start_q;
  logic                start_edge;
  logic                collide;

  assign start_edge = bus.start & ~start_q;

  // Overlap test runs one bit wider than X_W so x+OBS_W cannot wrap near the far right edge.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (({1'b0, obs_x_q[i]} < PLAYER_RIGHT) && (({1'b0, obs_x_q[i]} + OBS_W_C) > PLAYER_LEFT)) begin
        collide = 1'b1;
      end
    end
    collide = collide && (bus.jump_height < OBS_H_C);
  end

  always_comb begin
    state_d      = state_q;
    obs_x_d      = obs_x_q;
    level_d      = level_q;
    speed_d      = speed_q;
    game_time_d  = game_time_q;
    level_time_d = level_time_q;
    hit_d        = 1'b0;
    obs_valid_d  = '0;

    case (state_q)
      MENU: begin
        if (start_edge) begin
          state_d      = PLAY;
          level_d      = '0;
          speed_d      = SPEED0_C;
          game_time_d  = '0;
          level_time_d = '0;
          for (int i = 0; i < NUM_OBS; i++) begin
            obs_x_d[i] = X_W'(SCREEN_W + i * OBS_SPACING);
          end
        end
      end

      PLAY: begin
        if (bus.tick) begin
          if (collide) begin
            state_d = LOSE;
            hit_d   = 1'b1;
          end else begin
            // Wrapping by the full rotation length keeps the spawn pitch between obstacles intact.
            for (int i = 0; i < NUM_OBS; i++) begin
              if (obs_x_q[i] >= speed_q) begin
                obs_x_d[i] = obs_x_q[i] - speed_q;
              end else begin
                obs_x_d[i] = obs_x_q[i] + WRAP_C - speed_q;
              end
            end
            if (game_time_q != '1) begin
              game_time_d = game_time_q + 1'b1;
            end
            if (level_time_q == LT_LAST) begin
              level_time_d = '0;
              if (level_q == LVL_LAST) begin
                state_d = WIN;
              end else begin
                level_d = level_q + 1'b1;
                speed_d = speed_q + SPEED_STEP_C;
              end
            end else begin
              level_time_d = level_time_q + 1'b1;
            end
          end
        end
      end

      WIN, LOSE: begin
        if (start_edge) begin
          state_d = MENU;
        end
      end

      default: state_d = MENU;
    endcase

    for (int i = 0; i < NUM_OBS; i++) begin
      obs_valid_d[i] = (state_d != MENU) && (obs_x_d[i] < SCREEN_W_C);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MENU;
      level_q      <= '0;
      speed_q      <= SPEED0_C;
      game_time_q  <= '0;
      level_time_q <= '0;
      hit_q        <= 1'b0;
      start_q      <= 1'b0;
      obs_valid_q  <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x_q[i] <= X_W'(SCREEN_W + i * OBS_SPACING);
      end
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      speed_q      <= speed_d;
      game_time_q  <= game_time_d;
      level_time_q <= level_time_d;
      hit_q        <= hit_d;
      start_q      <= bus.start;
      obs_valid_q  <= obs_valid_d;
      obs_x_q      <= obs_x_d;
    end
  end

  always_comb begin
    bus.obs_x = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      bus.obs_x[i*X_W +: X_W] = obs_x_q[i];
    end
  end

  assign bus.obs_valid   = obs_valid_q;
  assign bus.level       = level_q;
  assign bus.game_time   = game_time_q;
  assign bus.hit         = hit_q;
  assign bus.menu_screen = (state_q == MENU);
  assign bus.play_screen = (state_q == PLAY);
  assign bus.win_screen  = (state_q == WIN);
  assign bus.lose_screen = (state_q == LOSE);

endmodule

// File: tb/tb_obstacle_level_engine.sv
// Directed and randomized bench for obstacle_level_engine, checked against an arithmetic game model.
// A second instance with short levels exercises level-up and WIN.
module tb_obstacle_level_engine;

  localparam int NUM_OBS     = 4;
  localparam int X_W         = 11;
  localparam int SCREEN_W    = 640;
  localparam int OBS_SPACING = 160;
  localparam int OBS_W       = 16;
  localparam int OBS_H       = 24;
  localparam int PLAYER_X    = 64;
  localparam int PLAYER_W    = 16;
  localparam int LEVEL_TICKS = 600;
  localparam int NUM_LEVELS  = 3;
  localparam int SPEED0      = 2;
  localparam int SPEED_STEP  = 1;
  localparam int TIME_MAX    = 2047;

  localparam int S_MENU = 0;
  localparam int S_PLAY = 1;
  localparam int S_WIN  = 2;
  localparam int S_LOSE = 3;

  logic clk = 1'b0;
  logic reset_n;

  int testsRun  = 0;
  int failCount = 0;

  int mState;
  int mX [NUM_OBS];
  int mLevel;
  int mTime;
  int mLevelTime;
  bit mHit;
  bit mStartPrev;

  always #10 clk = ~clk;

  obstacle_level_engine_if #(.NUM_OBS(4), .X_W(11), .JH_W(10), .TIME_W(11), .LVL_W(3)) ifA ();
  obstacle_level_engine_if #(.NUM_OBS(4), .X_W(11), .JH_W(10), .TIME_W(11), .LVL_W(2)) ifB ();

  obstacle_level_engine dutA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifA.slave)
  );

  obstacle_level_engine #(.LEVEL_TICKS(4), .NUM_LEVELS(2)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifB.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState     = S_MENU;
    mLevel     = 0;
    mTime      = 0;
    mLevelTime = 0;
    mHit       = 1'b0;
    mStartPrev = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) mX[i] = SCREEN_W + i * OBS_SPACING;
  endtask

  // One clock of game behaviour, evaluated from the rules on the values held before the edge.
  task automatic modelStep(input bit st, input bit tk, input int jh);
    bit rising;
    bit crash;
    int spd;
    rising = st && !mStartPrev;
    mHit   = 1'b0;
    crash  = 1'b0;
    case (mState)
      S_MENU: if (rising) begin
        mState     = S_PLAY;
        mLevel     = 0;
        mTime      = 0;
        mLevelTime = 0;
        for (int i = 0; i < NUM_OBS; i++) mX[i] = SCREEN_W + i * OBS_SPACING;
      end
      S_PLAY: if (tk) begin
        for (int i = 0; i < NUM_OBS; i++)
          if (mX[i] > PLAYER_X - OBS_W && mX[i] < PLAYER_X + PLAYER_W) crash = 1'b1;
        if (jh >= OBS_H) crash = 1'b0;
        if (crash) begin
          mState = S_LOSE;
          mHit   = 1'b1;
        end else begin
          spd = SPEED0 + mLevel * SPEED_STEP;
          for (int i = 0; i < NUM_OBS; i++) begin
            mX[i] = mX[i] - spd;
            if (mX[i] < 0) mX[i] = mX[i] + NUM_OBS * OBS_SPACING;
          end
          if (mTime < TIME_MAX) mTime++;
          mLevelTime++;
          if (mLevelTime == LEVEL_TICKS) begin
            mLevelTime = 0;
            if (mLevel == NUM_LEVELS - 1) mState = S_WIN;
            else mLevel++;
          end
        end
      end
      default: if (rising) mState = S_MENU;
    endcase
    mStartPrev = st;
  endtask

  task automatic compareAll(input string tag);
    logic [NUM_OBS*X_W-1:0] expX;
    logic [NUM_OBS-1:0]     expV;
    for (int i = 0; i < NUM_OBS; i++) begin
      expX[i*X_W +: X_W] = X_W'(mX[i]);
      expV[i] = (mState != S_MENU) && (mX[i] < SCREEN_W);
    end
    checkOutput({tag, ".obs_x"},     ifA.obs_x,       expX);
    checkOutput({tag, ".obs_valid"}, ifA.obs_valid,   expV);
    checkOutput({tag, ".level"},     ifA.level,       mLevel);
    checkOutput({tag, ".game_time"}, ifA.game_time,   mTime);
    checkOutput({tag, ".menu"},      ifA.menu_screen, mState == S_MENU);
    checkOutput({tag, ".play"},      ifA.play_screen, mState == S_PLAY);
    checkOutput({tag, ".win"},       ifA.win_screen,  mState == S_WIN);
    checkOutput({tag, ".lose"},      ifA.lose_screen, mState == S_LOSE);
    checkOutput({tag, ".hit"},       ifA.hit,         mHit);
  endtask

  task automatic applyStimulus(input bit st, input bit tk, input int jh, input string tag);
    ifA.start       = st;
    ifA.tick        = tk;
    ifA.jump_height = 10'(jh);
    modelStep(st, tk, jh);
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  task automatic stepB(input bit st, input bit tk);
    ifB.start       = st;
    ifB.tick        = tk;
    ifB.jump_height = 10'd100;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    ifA.start = 1'b0;
    ifA.tick  = 1'b0;
    reset_n   = 1'b0;
    #1;
    modelReset();
    checkOutput("rst.menu_now", ifA.menu_screen, 1);
    compareAll("rst");
    @(posedge clk);
    #5;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    ifA.start = 1'b0; ifA.tick = 1'b0; ifA.jump_height = '0;
    ifB.start = 1'b0; ifB.tick = 1'b0; ifB.jump_height = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.obs_x0", ifA.obs_x[10:0], 640);
    checkOutput("reset.obs_x1", ifA.obs_x[21:11], 800);
    checkOutput("reset.obs_valid", ifA.obs_valid, 0);
    compareAll("reset");
    reset_n = 1'b1;

    applyStimulus(1, 0, 100, "start");
    checkOutput("start.play", ifA.play_screen, 1);
    checkOutput("start.obs_x0", ifA.obs_x[10:0], 640);
    checkOutput("start.obs_x1", ifA.obs_x[21:11], 800);
    checkOutput("start.obs_valid", ifA.obs_valid, 0);

    for (int k = 0; k < 10; k++) applyStimulus(0, 1, 100, "scroll");
    checkOutput("scroll10.obs_x0", ifA.obs_x[10:0], 620);
    checkOutput("scroll10.game_time", ifA.game_time, 10);
    checkOutput("scroll10.level", ifA.level, 0);

    guard = 0;
    while (mX[0] != 0 && guard < 400) begin
      applyStimulus(0, 1, 100, "toward_wrap");
      guard++;
    end
    checkOutput("wrap.reached_zero", ifA.obs_x[10:0], 0);
    applyStimulus(0, 1, 100, "wrap");
    checkOutput("wrap.obs_x0", ifA.obs_x[10:0], 638);
    checkOutput("wrap.valid0", ifA.obs_valid[0], 1);

    for (int k = 0; k < 3000; k++) begin
      bit st;
      bit tk;
      int jh;
      st = ($urandom_range(0, 15) == 0);
      tk = 1'($urandom_range(0, 1));
      jh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 23)) : int'($urandom_range(24, 1023));
      applyStimulus(st, tk, jh, "random");
    end

    pulseReset();
    applyStimulus(1, 0, 100, "c_start");
    applyStimulus(0, 0, 100, "c_release");
    guard = 0;
    while (mX[0] != 70 && guard < 400) begin
      applyStimulus(0, 1, 100, "toward_70");
      guard++;
    end
    checkOutput("collide.pre_x0", ifA.obs_x[10:0], 70);
    applyStimulus(0, 1, 0, "collide");
    checkOutput("collide.lose", ifA.lose_screen, 1);
    checkOutput("collide.hit", ifA.hit, 1);
    checkOutput("collide.obs_x0", ifA.obs_x[10:0], 70);
    applyStimulus(0, 1, 0, "after_hit");
    checkOutput("after_hit.hit", ifA.hit, 0);
    checkOutput("after_hit.obs_x0", ifA.obs_x[10:0], 70);
    applyStimulus(1, 0, 0, "lose_to_menu");
    checkOutput("lose_to_menu.menu", ifA.menu_screen, 1);
    applyStimulus(0, 0, 0, "menu_idle");

    applyStimulus(1, 0, 100, "m_start");
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 100, "m_play");
    pulseReset();
    checkOutput("rst_mid.hit", ifA.hit, 0);

    stepB(1, 0);
    checkOutput("b.play", ifB.play_screen, 1);
    for (int k = 0; k < 4; k++) stepB(0, 1);
    checkOutput("b.level_after4", ifB.level, 1);
    checkOutput("b.x0_after4", ifB.obs_x[10:0], 632);
    stepB(0, 1);
    checkOutput("b.x0_speed3", ifB.obs_x[10:0], 629);
    stepB(0, 1);
    stepB(0, 1);
    checkOutput("b.still_play", ifB.play_screen, 1);
    stepB(0, 1);
    checkOutput("b.win", ifB.win_screen, 1);
    checkOutput("b.win_level", ifB.level, 1);
    checkOutput("b.win_x0", ifB.obs_x[10:0], 620);
    checkOutput("b.win_time", ifB.game_time, 8);
    stepB(0, 1);
    checkOutput("b.win_frozen_x0", ifB.obs_x[10:0], 620);
    checkOutput("b.win_valid", ifB.obs_valid, 4'b0001);
    stepB(1, 0);
    checkOutput("b.to_menu", ifB.menu_screen, 1);
    checkOutput("b.menu_valid", ifB.obs_valid, 0);
    for (int k = 0; k < 3; k++) stepB(1, 0);
    checkOutput("b.held_start_menu", ifB.menu_screen, 1);
    checkOutput("b.held_start_noplay", ifB.play_screen, 0);
    stepB(0, 0);
    stepB(1, 0);
    checkOutput("b.restart_play", ifB.play_screen, 1);
    checkOutput("b.restart_level", ifB.level, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
